// File: rtl/control_unit_if.sv
// control_unit_if: decode request and registered ALU-control result bundle.
// The illegal/illegal_sticky signals exist only when CU_ILLEGAL_DET_EN is defined.
interface control_unit_if;
    logic       in_valid;
    logic [5:0] function_code;
    logic [2:0] select_bits_ALU;
    logic       out_valid;
    logic       ovf_check_en;
    logic       shift_op;
`ifdef CU_ILLEGAL_DET_EN
    logic       illegal;
    logic       illegal_sticky;

    modport master (
        output in_valid, function_code,
        input  select_bits_ALU, out_valid, ovf_check_en, shift_op,
               illegal, illegal_sticky
    );
    modport slave (
        input  in_valid, function_code,
        output select_bits_ALU, out_valid, ovf_check_en, shift_op,
               illegal, illegal_sticky
    );
`else
    modport master (
        output in_valid, function_code,
        input  select_bits_ALU, out_valid, ovf_check_en, shift_op
    );
    modport slave (
        input  in_valid, function_code,
        output select_bits_ALU, out_valid, ovf_check_en, shift_op
    );
`endif
endinterface

// File: rtl/control_unit.sv
// control_unit: MIPS R-type funct -> ALU select decoder with a one-cycle
// registered output. Optional illegal-code detection is compiled in with
// the CU_ILLEGAL_DET_EN macro.
module control_unit (
    input  logic         clk,
    input  logic         rst,
    control_unit_if.slave bus
);

    typedef struct packed {
        logic [2:0] sel;
        logic       ovf_chk;
        logic       shift;
`ifdef CU_ILLEGAL_DET_EN
        logic       ill;
`endif
    } dec_t;

    // Unknown codes fall back to the add select with no side-band flags.
    function automatic dec_t decode(input logic [5:0] funct);
        dec_t d;
        d.sel     = 3'b010;
        d.ovf_chk = 1'b0;
        d.shift   = 1'b0;
`ifdef CU_ILLEGAL_DET_EN
        d.ill     = 1'b0;
`endif
        case (funct)
            6'b100000: begin d.sel = 3'b010; d.ovf_chk = 1'b1; end
            6'b100001: d.sel = 3'b010;
            6'b100010: begin d.sel = 3'b110; d.ovf_chk = 1'b1; end
            6'b100011: d.sel = 3'b110;
            6'b100100: d.sel = 3'b000;
            6'b100101: d.sel = 3'b001;
            6'b100111: d.sel = 3'b011;
            6'b101011: d.sel = 3'b111;
            6'b000000: begin d.sel = 3'b100; d.shift = 1'b1; end
            6'b000010: begin d.sel = 3'b101; d.shift = 1'b1; end
            default: begin
`ifdef CU_ILLEGAL_DET_EN
                d.ill = 1'b1;
`endif
            end
        endcase
        return d;
    endfunction

    dec_t       dec_p0;
    logic [2:0] sel_p1;
    logic       ovf_chk_p1;
    logic       shift_p1;
    logic       vld_p1;

    // Combinational decode of the incoming funct field.
    always_comb dec_p0 = decode(bus.function_code);

    // ---- stage p0 -> p1: register decode; data holds when not valid ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_p1     <= 3'b010;
            ovf_chk_p1 <= 1'b0;
            shift_p1   <= 1'b0;
            vld_p1     <= 1'b0;
        end else begin
            vld_p1 <= bus.in_valid;
            if (bus.in_valid) begin
                sel_p1     <= dec_p0.sel;
                ovf_chk_p1 <= dec_p0.ovf_chk;
                shift_p1   <= dec_p0.shift;
            end
        end
    end

    assign bus.select_bits_ALU = sel_p1;
    assign bus.ovf_check_en    = ovf_chk_p1;
    assign bus.shift_op        = shift_p1;
    assign bus.out_valid       = vld_p1;

`ifdef CU_ILLEGAL_DET_EN
    logic ill_p1;
    logic ill_sticky_p1;

    // Per-result illegal flag plus a sticky copy that only reset clears.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ill_p1        <= 1'b0;
            ill_sticky_p1 <= 1'b0;
        end else begin
            ill_p1 <= bus.in_valid & dec_p0.ill;
            if (bus.in_valid & dec_p0.ill)
                ill_sticky_p1 <= 1'b1;
        end
    end

    assign bus.illegal        = ill_p1;
    assign bus.illegal_sticky = ill_sticky_p1;
`endif

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: scoreboard bench for control_unit. Stimulus pushes the
// reference model's expected outputs; a monitor pops and compares them.
module tb_control_unit;

    logic clk;
    logic rst;

    control_unit_if bus();

    control_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] sel;
        logic       ovf;
        logic       shf;
        logic       vld;
        logic       ill;
        logic       sticky;
    } exp_t;

    exp_t       sb_q[$];
    int         n_checks = 0;
    int         n_fail   = 0;

    // Reference model: table of legal codes, plus remembered output state.
    logic [4:0] legal_tab [logic [5:0]];   // {sel, ovf, shf}
    logic [2:0] m_sel;
    logic       m_ovf, m_shf, m_sticky;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_sel = 3'b010; m_ovf = 1'b0; m_shf = 1'b0; m_sticky = 1'b0;
    endtask

    // Advance the model by one sampled edge and return the expected outputs.
    function automatic exp_t model_step(input logic v, input logic [5:0] f);
        exp_t e;
        logic bad;
        bad = 1'b0;
        if (v) begin
            if (legal_tab.exists(f)) begin
                {m_sel, m_ovf, m_shf} = legal_tab[f];
            end else begin
                m_sel = 3'b010; m_ovf = 1'b0; m_shf = 1'b0; bad = 1'b1;
            end
        end
        if (bad) m_sticky = 1'b1;
        e.sel = m_sel; e.ovf = m_ovf; e.shf = m_shf; e.vld = v;
        e.ill = bad; e.sticky = m_sticky;
        return e;
    endfunction

    task automatic drive(input logic v, input logic [5:0] f);
        @(posedge clk);
        #2;
        bus.in_valid      = v;
        bus.function_code = f;
        sb_q.push_back(model_step(v, f));
    endtask

    task automatic drain();
        int budget;
        drive(1'b0, 6'b111111);
        budget = 10;
        while (sb_q.size() > 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        #2;
        check("drain_timeout", sb_q.size(), 0);
    endtask

    // Asynchronous reset mid-cycle, checked immediately; the first edge
    // after release samples a valid sub.
    task automatic do_reset();
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("rst_sel", int'(bus.select_bits_ALU), 2);
        check("rst_vld", int'(bus.out_valid), 0);
        check("rst_ovf", int'(bus.ovf_check_en), 0);
        check("rst_shf", int'(bus.shift_op), 0);
`ifdef CU_ILLEGAL_DET_EN
        check("rst_ill", int'(bus.illegal), 0);
        check("rst_sticky", int'(bus.illegal_sticky), 0);
`endif
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        bus.in_valid      = 1'b1;
        bus.function_code = 6'b100010;
        rst = 1'b0;
        sb_q.push_back(model_step(1'b1, 6'b100010));
    endtask

    // Monitor: compare whatever the DUT presents against the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("out_valid", int'(bus.out_valid), int'(e.vld));
                check("select", int'(bus.select_bits_ALU), int'(e.sel));
                check("ovf_check_en", int'(bus.ovf_check_en), int'(e.ovf));
                check("shift_op", int'(bus.shift_op), int'(e.shf));
`ifdef CU_ILLEGAL_DET_EN
                check("illegal", int'(bus.illegal), int'(e.ill));
                check("illegal_sticky", int'(bus.illegal_sticky), int'(e.sticky));
`endif
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, %0d checks", n_checks);
        $fatal(1, "timeout");
    end

    logic [5:0] sweep [10];
    logic [5:0] code;

    initial begin
        legal_tab[6'b100000] = {3'b010, 1'b1, 1'b0};
        legal_tab[6'b100001] = {3'b010, 1'b0, 1'b0};
        legal_tab[6'b100010] = {3'b110, 1'b1, 1'b0};
        legal_tab[6'b100011] = {3'b110, 1'b0, 1'b0};
        legal_tab[6'b100100] = {3'b000, 1'b0, 1'b0};
        legal_tab[6'b100101] = {3'b001, 1'b0, 1'b0};
        legal_tab[6'b100111] = {3'b011, 1'b0, 1'b0};
        legal_tab[6'b101011] = {3'b111, 1'b0, 1'b0};
        legal_tab[6'b000000] = {3'b100, 1'b0, 1'b1};
        legal_tab[6'b000010] = {3'b101, 1'b0, 1'b1};
        sweep = '{6'b100000, 6'b100001, 6'b100100, 6'b100111, 6'b100101,
                  6'b101011, 6'b000000, 6'b000010, 6'b100010, 6'b100011};

        model_reset();
        bus.in_valid      = 1'b0;
        bus.function_code = 6'b000000;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("init_sel", int'(bus.select_bits_ALU), 2);
        check("init_vld", int'(bus.out_valid), 0);
        @(negedge clk);
        rst = 1'b0;

        // Legal sweep, one per cycle.
        foreach (sweep[i]) drive(1'b1, sweep[i]);
        // Valid drop: select must hold at the and-code value.
        drive(1'b1, 6'b100100);
        drive(1'b0, 6'b100101);
        drive(1'b0, 6'b100101);
        // Illegal code, then legal add; sticky persists.
        drive(1'b1, 6'b111111);
        drive(1'b1, 6'b100000);
        drive(1'b0, 6'b000000);
        drain();
        do_reset();
        // Illegal code while not valid must set nothing.
        drive(1'b0, 6'b111111);
        drive(1'b0, 6'b110011);
        drive(1'b1, 6'b000010);

        // Randomized traffic, biased toward legal codes.
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(3, 0) != 0)
                code = sweep[$urandom_range(9, 0)];
            else
                code = 6'($urandom);
            drive(1'($urandom_range(4, 0) != 0), code);
        end
        drain();
        do_reset();
        drive(1'b1, 6'b101011);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/control_unit.md
# control_unit

ALU-control decoder for the single-cycle MIPS datapath. Takes the 6-bit R-type function field, decodes it to the 3-bit ALU operation select plus side-band flags, and registers the result for the ALU stage. It sits between instruction decode and the ALU and is the only source of ALU select in the core.

## Interface

Clock and reset: one clock; reset is asynchronous and active-high (ports `clk`, `rst`).

Parameters:
- none

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  function_code is valid this cycle
- function_code  input  6  R-type funct field
- select_bits_ALU  output  3  registered ALU operation select
- out_valid  output  1  registered copy of in_valid
- ovf_check_en  output  1  ALU must flag signed overflow (add/sub only)
- shift_op  output  1  operation is a shift (ALU uses shamt)
- illegal  output  1  unrecognised funct this result (CU_ILLEGAL_DET_EN only)
- illegal_sticky  output  1  set on any illegal decode, cleared only by rst (CU_ILLEGAL_DET_EN only)

## Operation

- Decode table (funct -> select, ovf_check_en, shift_op):
  - 100000 add -> 010, 1, 0
  - 100001 addu -> 010, 0, 0
  - 100010 sub -> 110, 1, 0
  - 100011 subu -> 110, 0, 0
  - 100100 and -> 000, 0, 0
  - 100101 or -> 001, 0, 0
  - 100111 nor -> 011, 0, 0
  - 101011 sltu -> 111, 0, 0
  - 000000 sll -> 100, 0, 1
  - 000010 srl -> 101, 0, 1
  - any other code -> 010, 0, 0 (illegal)
- Decode is purely combinational. All outputs are flops loaded from it.
- in_valid=1 at a clock edge: select_bits_ALU, ovf_check_en, shift_op and illegal load the decoded values. out_valid loads 1.
- in_valid=0 at a clock edge: select_bits_ALU, ovf_check_en and shift_op hold. illegal loads 0. out_valid loads 0.
- function_code is ignored while in_valid=0. Illegal codes presented with in_valid=0 set nothing.

## Timing

- Latency: exactly 1 cycle, from the in_valid/function_code sample edge to the outputs. Throughput is one decode per cycle with no stall and no backpressure.
- Reset values (asserted asynchronously, held while rst=1): select_bits_ALU=010, out_valid=0, ovf_check_en=0, shift_op=0, illegal=0, illegal_sticky=0.
- Reset deasserted mid-stream: the first edge with rst=0 samples normally.
- illegal_sticky is set on the same edge that illegal goes 1. It stays 1 until rst.
- Back-to-back valid codes: each edge's outputs reflect only that edge's input. There is no carry-over.

## Configuration

- CU_ILLEGAL_DET_EN defined: the illegal and illegal_sticky ports and their logic are compiled in, as described above.
- CU_ILLEGAL_DET_EN undefined: both ports are absent. Unknown codes still decode silently to 010/0/0 with out_valid=1.

## Test plan

- Reset: assert rst asynchronously mid-cycle -> outputs immediately 010/0/0/0, illegal_sticky=0.
- Sweep all ten legal codes with in_valid=1, one per cycle (100000, 100001, 100100, 100111, 100101, 101011, 000000, 000010, 100010, 100011) -> next cycle select = 010, 010, 000, 011, 001, 111, 100, 101, 110, 110. ovf_check_en=1 only for 100000 and 100010. shift_op=1 only for 000000 and 000010.
- in_valid drop: valid 100100, then in_valid=0 with funct 100101 -> select stays 000, out_valid=0.
- Illegal code (macro on): 111111 valid -> select 010, illegal=1 for one cycle, illegal_sticky=1. It stays 1 after legal 100000 follows, and clears on rst.
- Illegal code with in_valid=0 (macro on): 111111 -> illegal and illegal_sticky stay 0.
- Macro off: 111111 valid -> select 010, out_valid=1, ovf_check_en=0, shift_op=0.
